// File: rtl/avalon_st_to_sdram_burst_writer_if.sv
// ---------------------------------------------------------------------------
// avalon_st_to_sdram_burst_writer_if
//
// Bundles the three buses of the streaming-to-SDRAM write engine:
//   - command channel : st_instruction_valid/ready/addr/len
//   - data stream     : st_valid/st_data/st_ready (Avalon-ST sink)
//   - memory master   : mm_addr/byteenable/burstcount/write/writedata,
//                       mm_waitrequest (Avalon-MM burst master)
//
// Modports:
//   master : the writer engine (issues Avalon-MM bursts, sinks command/stream)
//   slave  : the environment around it (sources command/stream, acts as the
//            memory slave)
// ---------------------------------------------------------------------------
interface avalon_st_to_sdram_burst_writer_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 16
);
  // command channel
  logic                  st_instruction_valid;
  logic                  st_instruction_ready;
  logic [31:0]           st_instruction_addr;
  logic [LEN_W-1:0]      st_instruction_len;

  // data stream
  logic                  st_valid;
  logic [DATA_W-1:0]     st_data;
  logic                  st_ready;

  // Avalon-MM burst master
  logic [ADDR_W-1:0]     mm_addr;
  logic [DATA_W/8-1:0]   mm_byteenable;
  logic [7:0]            mm_burstcount;
  logic                  mm_write;
  logic [DATA_W-1:0]     mm_writedata;
  logic                  mm_waitrequest;

  modport master (
    input  st_instruction_valid,
    output st_instruction_ready,
    input  st_instruction_addr,
    input  st_instruction_len,
    input  st_valid,
    input  st_data,
    output st_ready,
    output mm_addr,
    output mm_byteenable,
    output mm_burstcount,
    output mm_write,
    output mm_writedata,
    input  mm_waitrequest
  );

  modport slave (
    output st_instruction_valid,
    input  st_instruction_ready,
    output st_instruction_addr,
    output st_instruction_len,
    output st_valid,
    output st_data,
    input  st_ready,
    input  mm_addr,
    input  mm_byteenable,
    input  mm_burstcount,
    input  mm_write,
    input  mm_writedata,
    output mm_waitrequest
  );
endinterface

// File: rtl/avalon_st_to_sdram_burst_writer.sv
// ---------------------------------------------------------------------------
// avalon_st_to_sdram_burst_writer
//
// Accepts a command {byte address, beat count}, then drains that many beats
// from an Avalon-ST stream into Avalon-MM write bursts of at most MAX_BURST
// beats each. Long transfers are split into back-to-back bursts. A small
// CSR port exposes state, a burst counter, a beat counter and live status.
//
// Ports:
//   clock, reset   : single clock, synchronous active-high reset
//   bus (master)   : command channel, Avalon-ST sink, Avalon-MM burst master
//   done           : one-cycle pulse after the final beat of a command is
//                    accepted by the slave
//   csr_address    : CSR byte address (0, 4, 8, 12 decoded)
//   csr_read       : CSR read strobe (data is refreshed every cycle anyway)
//   csr_readdata   : registered CSR read data
// ---------------------------------------------------------------------------
module avalon_st_to_sdram_burst_writer #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 27,
  parameter int MAX_BURST  = 8,
  parameter int LEN_W      = 16,
  parameter int SWAP_BYTES = 1
) (
  input  logic        clock,
  input  logic        reset,
  avalon_st_to_sdram_burst_writer_if.master bus,
  output logic        done,
  input  logic [3:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata
);

  localparam int NUM_BYTES  = DATA_W / 8;
  localparam int BYTE_SHIFT = $clog2(NUM_BYTES);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // burst bookkeeping
  logic [ADDR_W-1:0]  addr_reg;
  logic [7:0]         burst_reg;
  logic [7:0]         load_left_reg;   // beats still to pull from the stream
  logic [7:0]         ack_left_reg;    // beats still to be accepted by slave
  logic [LEN_W-1:0]   total_reg;       // beats of the command not yet accepted

  // single-beat output register
  logic               mm_write_reg;
  logic [DATA_W-1:0]  writedata_reg;

  logic               done_reg;
  logic [31:0]        burst_cnt_reg;
  logic [31:0]        beat_cnt_reg;
  logic [31:0]        csr_readdata_reg;
  logic [31:0]        csr_readdata_next;

  // combinational helpers
  logic               instr_ready_c;
  logic               st_ready_c;
  logic               cmd_start;
  logic               load;
  logic               accept;
  logic               burst_end;
  logic               xfer_end;
  logic [31:0]        word_addr;
  logic [7:0]         cmd_burst;
  logic [7:0]         next_burst;
  logic [DATA_W-1:0]  swapped_data;
  logic               unused_inputs;

  // min(n, MAX_BURST), evaluated in 32 bits so a narrow LEN_W cannot
  // truncate the comparison.
  function automatic logic [7:0] clamp_burst(input logic [LEN_W-1:0] n);
    if (32'(n) > MAX_BURST) begin
      return 8'(MAX_BURST);
    end
    return 8'(n);
  endfunction

  // -------------------------------------------------------------------------
  // Byte reordering of the incoming beat (pure wiring)
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      if (SWAP_BYTES != 0) begin : g_swap
        assign swapped_data[gi*8 +: 8] = bus.st_data[(NUM_BYTES-1-gi)*8 +: 8];
      end else begin : g_pass
        assign swapped_data[gi*8 +: 8] = bus.st_data[gi*8 +: 8];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Event decode
  // -------------------------------------------------------------------------
  assign cmd_start  = instr_ready_c && bus.st_instruction_valid &&
                      (bus.st_instruction_len != '0);
  assign load       = bus.st_valid && st_ready_c;
  assign accept     = mm_write_reg && !bus.mm_waitrequest;
  assign burst_end  = accept && (ack_left_reg == 8'd1);
  assign xfer_end   = burst_end && (total_reg == LEN_W'(1));

  // Low address bits select a byte inside a beat and are dropped here.
  assign word_addr  = bus.st_instruction_addr >> BYTE_SHIFT;
  assign cmd_burst  = clamp_burst(bus.st_instruction_len);
  assign next_burst = clamp_burst(total_reg - LEN_W'(1));

  // The read strobe carries no information: read data is refreshed each cycle.
  assign unused_inputs = csr_read;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_start) state_next = WRITE;
      WRITE:   if (xfer_end)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: combinational outputs
  // A new beat may be pulled while the output register is empty or is being
  // emptied this very cycle, so st_ready depends on mm_waitrequest directly.
  // -------------------------------------------------------------------------
  always_comb begin
    instr_ready_c = 1'b0;
    st_ready_c    = 1'b0;
    case (state_reg)
      IDLE:    instr_ready_c = 1'b1;
      WRITE:   st_ready_c    = (load_left_reg != 8'd0) &&
                               (!mm_write_reg || !bus.mm_waitrequest);
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: burst bookkeeping, output register, counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg      <= '0;
      burst_reg     <= '0;
      load_left_reg <= '0;
      ack_left_reg  <= '0;
      total_reg     <= '0;
      mm_write_reg  <= 1'b0;
      writedata_reg <= '0;
      done_reg      <= 1'b0;
      burst_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
    end else begin
      done_reg <= xfer_end;

      if (cmd_start) begin
        addr_reg      <= ADDR_W'(word_addr);
        total_reg     <= bus.st_instruction_len;
        burst_reg     <= cmd_burst;
        load_left_reg <= cmd_burst;
        ack_left_reg  <= cmd_burst;
        burst_cnt_reg <= burst_cnt_reg + 32'd1;
      end

      if (state_reg == WRITE) begin
        // A loading beat takes priority: the register is refilled in the
        // same cycle the held beat leaves.
        if (load) begin
          writedata_reg <= swapped_data;
          mm_write_reg  <= 1'b1;
        end else if (accept) begin
          mm_write_reg  <= 1'b0;
        end

        if (accept) begin
          total_reg    <= total_reg - LEN_W'(1);
          beat_cnt_reg <= beat_cnt_reg + 32'd1;
        end

        // On the last accept of a burst nothing can load (load_left is
        // already zero), so reloading both counters here is safe. The
        // following cycle pulls the first beat of the next burst, which
        // leaves exactly one idle cycle on mm_write.
        if (burst_end && !xfer_end) begin
          addr_reg      <= addr_reg + ADDR_W'(burst_reg);
          burst_reg     <= next_burst;
          load_left_reg <= next_burst;
          ack_left_reg  <= next_burst;
          burst_cnt_reg <= burst_cnt_reg + 32'd1;
        end else begin
          if (load) begin
            load_left_reg <= load_left_reg - 8'd1;
          end
          if (accept) begin
            ack_left_reg <= ack_left_reg - 8'd1;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // CSR read mux, registered every cycle
  // -------------------------------------------------------------------------
  always_comb begin
    csr_readdata_next = 32'hDEAD_BEEF;
    case (csr_address)
      4'd0:  csr_readdata_next = {31'b0, state_reg == WRITE};
      4'd4:  csr_readdata_next = burst_cnt_reg;
      4'd8:  csr_readdata_next = beat_cnt_reg;
      4'd12: csr_readdata_next = {22'b0, done_reg, mm_write_reg,
                                  bus.mm_waitrequest, bus.st_instruction_valid,
                                  instr_ready_c, bus.st_valid, st_ready_c,
                                  3'b0};
      default: csr_readdata_next = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csr_readdata_reg <= '0;
    end else begin
      csr_readdata_reg <= csr_readdata_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.st_instruction_ready = instr_ready_c;
  assign bus.st_ready             = st_ready_c;
  assign bus.mm_addr              = addr_reg;
  assign bus.mm_burstcount        = burst_reg;
  assign bus.mm_write             = mm_write_reg;
  assign bus.mm_writedata         = writedata_reg;
  assign bus.mm_byteenable        = {NUM_BYTES{mm_write_reg}};
  assign done                     = done_reg;
  assign csr_readdata             = csr_readdata_reg;

endmodule

// File: tb/tb_avalon_st_to_sdram_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_avalon_st_to_sdram_burst_writer
//
// Drives a table of commands through the writer with clean, random, stalled
// and starved traffic and compares every slave-accepted beat against a
// reference list derived from the command (word address, burst split,
// byte-swapped data). Hand sequences cover reset state, zero-length
// commands and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_avalon_st_to_sdram_burst_writer;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 27;
  localparam int MAX_BURST = 8;
  localparam int LEN_W     = 16;
  localparam int NB        = DATA_W / 8;
  localparam int CYC_LIMIT = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        done;
  logic [3:0]  csr_address = 4'd0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_readdata;

  always #5 clock = ~clock;

  avalon_st_to_sdram_burst_writer_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) bus ();

  avalon_st_to_sdram_burst_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST),
    .LEN_W(LEN_W), .SWAP_BYTES(1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .done         (done),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] data;
  } beat_t;

  // mode: 0 clean, 1 random valid/waitrequest, 2 3-cycle stall on beat 2,
  //       3 5-cycle stream gap after 3 beats, 4 clean but abandon after 3 accepts
  typedef struct {
    logic [31:0]       addr;
    int                len;
    int                mode;
    int                exp_bursts;
    int                exp_beats;
    logic [ADDR_W-1:0] exp_word;
  } vec_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] stream_q[$];
  int                acc_cycle[$];
  int                cmd_cycle;
  int                done_pulses;
  logic [ADDR_W-1:0] first_addr;
  bit                got_first;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = d[(NB-1-b)*8 +: 8];
    return r;
  endfunction

  // Reference: beat i of a command goes to burst i/MAX_BURST, which starts at
  // word + (i/MAX_BURST)*MAX_BURST and carries min(remaining, MAX_BURST) beats.
  task automatic plan_cmd(input logic [31:0] addr, input int len);
    logic [31:0] word;
    word = addr / NB;
    for (int i = 0; i < len; i++) begin
      beat_t             b;
      logic [DATA_W-1:0] d;
      int                base;
      base = (i / MAX_BURST) * MAX_BURST;
      for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
      stream_q.push_back(d);
      b.addr = ADDR_W'(word + base);
      b.cnt  = 8'(((len - base) < MAX_BURST) ? (len - base) : MAX_BURST);
      b.data = swap_bytes(d);
      exp_q.push_back(b);
    end
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clock);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clock);
    d        = csr_readdata;
    csr_read = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int len, input int mode);
    bit                cmd_pending = 1'b1;
    bit                done_due    = 1'b0;
    bit                hold_prev   = 1'b0;
    bit                in_gap;
    logic [DATA_W-1:0] hold_data = '0;
    logic [NB-1:0]     be_exp;
    logic [ADDR_W-1:0] gap_addr = '0;
    logic [7:0]        gap_bc = '0;
    int                cycles = 0;
    int                accepts = 0;
    int                loads = 0;
    int                wcnt = 0;
    int                gap = 0;
    stream_q.delete();
    exp_q.delete();
    acc_cycle.delete();
    done_pulses = 0;
    got_first   = 1'b0;
    cmd_cycle   = -1;
    plan_cmd(addr, len);
    while ((cmd_pending || exp_q.size() != 0 || done_due) && cycles < CYC_LIMIT) begin
      if (mode == 4 && accepts == 3) break;
      @(negedge clock);
      bus.st_instruction_valid = cmd_pending;
      bus.st_instruction_addr  = addr;
      bus.st_instruction_len   = LEN_W'(len);
      case (mode)
        1:       bus.mm_waitrequest = ($urandom_range(0, 3) == 0);
        2:       bus.mm_waitrequest = bus.mm_write && (accepts == 1) && (wcnt < 3);
        default: bus.mm_waitrequest = 1'b0;
      endcase
      if (mode == 2 && bus.mm_waitrequest) wcnt++;
      in_gap = (mode == 3) && (loads == 3) && (gap < 5);
      bus.st_valid = (stream_q.size() != 0) && !in_gap &&
                     ((mode != 1) || ($urandom_range(0, 3) != 0));
      bus.st_data  = (stream_q.size() != 0) ? stream_q[0] : '0;
      #1;
      check("done", done, done_due);
      if (done) done_pulses++;
      be_exp = bus.mm_write ? {NB{1'b1}} : '0;
      check("byteenable", bus.mm_byteenable, be_exp);
      if (hold_prev) begin
        check("hold_mm_write", bus.mm_write, 1);
        check("hold_writedata", bus.mm_writedata, hold_data);
      end
      if (bus.mm_write && bus.mm_waitrequest) check("stall_st_ready", bus.st_ready, 0);
      if (in_gap) begin
        if (gap == 0) begin
          gap_addr = bus.mm_addr;
          gap_bc   = bus.mm_burstcount;
        end else begin
          check("gap_mm_write", bus.mm_write, 0);
          check("gap_mm_addr", bus.mm_addr, gap_addr);
          check("gap_burstcount", bus.mm_burstcount, gap_bc);
        end
        gap++;
      end
      hold_prev = bus.mm_write && bus.mm_waitrequest;
      hold_data = bus.mm_writedata;
      done_due  = 1'b0;
      if (bus.st_instruction_valid && bus.st_instruction_ready) begin
        cmd_pending = 1'b0;
        cmd_cycle   = cycles;
      end
      if (bus.st_valid && bus.st_ready) begin
        void'(stream_q.pop_front());
        loads++;
      end
      if (bus.mm_write && !bus.mm_waitrequest) begin
        accepts++;
        acc_cycle.push_back(cycles);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got addr %h data %h expected no beat",
                   bus.mm_addr, bus.mm_writedata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", bus.mm_addr, e.addr);
          check("beat_burstcount", bus.mm_burstcount, e.cnt);
          check("beat_data", bus.mm_writedata, e.data);
          if (!got_first) begin
            first_addr = bus.mm_addr;
            got_first  = 1'b1;
          end
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
      cycles++;
    end
    if (cycles >= CYC_LIMIT) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d beats left after %0d cycles expected 0",
               exp_q.size(), cycles);
    end
    bus.st_instruction_valid = 1'b0;
    bus.st_valid             = 1'b0;
    bus.mm_waitrequest       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mm_write"}, bus.mm_write, 0);
    check({tag, "_mm_addr"}, bus.mm_addr, 0);
    check({tag, "_mm_burstcount"}, bus.mm_burstcount, 0);
    check({tag, "_mm_byteenable"}, bus.mm_byteenable, 0);
    check({tag, "_mm_writedata"}, bus.mm_writedata, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_csr_readdata"}, csr_readdata, 0);
  endtask

  initial begin
    vec_t        tv[9];
    logic [31:0] rd;
    int          exp_bursts = 0;
    int          exp_beats  = 0;
    int          gap_exp;

    tv[0] = '{32'h0000_0100,  8, 0, 1,  8, 27'h8};
    tv[1] = '{32'h0000_0000, 20, 0, 3, 20, 27'h0};
    tv[2] = '{32'h0000_0400,  6, 2, 1,  6, 27'h20};
    tv[3] = '{32'h0000_0800,  8, 3, 1,  8, 27'h40};
    tv[4] = '{32'h0000_0040,  0, 0, 0,  0, 27'h0};
    tv[5] = '{32'h0000_1000,  1, 0, 1,  1, 27'h80};
    tv[6] = '{32'h0000_0025,  9, 1, 2,  9, 27'h1};
    tv[7] = '{32'hFFFF_FFE0,  3, 1, 1,  3, 27'h7FF_FFFF};
    tv[8] = '{32'h0000_2000, 17, 1, 3, 17, 27'h100};

    bus.st_instruction_valid = 1'b0;
    bus.st_instruction_addr  = '0;
    bus.st_instruction_len   = '0;
    bus.st_valid             = 1'b0;
    bus.st_data              = '0;
    bus.mm_waitrequest       = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    csr_rd(4'd0, rd);  check("csr_state_idle", rd, 0);
    csr_rd(4'd12, rd); check("csr_status_idle", rd, 32'h0000_0020);
    csr_rd(4'd5, rd);  check("csr_unmapped", rd, 32'hDEAD_BEEF);
    $display("reset: status and CSR checked");

    // table-driven commands
    for (int v = 0; v < 9; v++) begin
      run_cmd(tv[v].addr, tv[v].len, tv[v].mode);
      exp_bursts += tv[v].exp_bursts;
      exp_beats  += tv[v].exp_beats;
      check("beats_accepted", acc_cycle.size(), tv[v].exp_beats);
      check("done_pulses", done_pulses, (tv[v].len > 0) ? 1 : 0);
      if (tv[v].len > 0) check("first_mm_addr", first_addr, tv[v].exp_word);
      if (tv[v].mode == 0 && tv[v].len > 0) begin
        check("first_beat_latency", acc_cycle[0] - cmd_cycle, 2);
        for (int i = 0; i + 1 < acc_cycle.size(); i++) begin
          gap_exp = (((i + 1) % MAX_BURST) == 0) ? 2 : 1;
          check("accept_spacing", acc_cycle[i+1] - acc_cycle[i], gap_exp);
        end
      end
      if (tv[v].len == 0) begin
        check("zero_len_accept_cycle", cmd_cycle, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          #1;
          check("zero_len_idle_ready", bus.st_instruction_ready, 1);
          check("zero_len_no_write", bus.mm_write, 0);
          check("zero_len_no_done", done, 0);
        end
      end
      csr_rd(4'd4, rd); check("csr_bursts", rd, exp_bursts);
      csr_rd(4'd8, rd); check("csr_beats", rd, exp_beats);
      $display("cmd addr=%h len=%0d mode=%0d beats=%0d bursts_total=%0d beats_total=%0d",
               tv[v].addr, tv[v].len, tv[v].mode, acc_cycle.size(), rd == 32'(exp_beats) ? exp_bursts : -1, rd);
    end

    // reset in the middle of a burst
    run_cmd(32'h0000_0000, 8, 4);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset = 1'b0;
    csr_rd(4'd0, rd); check("midreset_csr_state", rd, 0);
    csr_rd(4'd4, rd); check("midreset_csr_bursts", rd, 0);
    csr_rd(4'd8, rd); check("midreset_csr_beats", rd, 0);
    $display("midreset: abandoned after 3 beats, state cleared");

    run_cmd(32'h0000_0300, 5, 1);
    check("post_reset_beats", acc_cycle.size(), 5);
    check("post_reset_done", done_pulses, 1);
    check("post_reset_first_addr", first_addr, 27'h18);
    csr_rd(4'd4, rd); check("post_reset_csr_bursts", rd, 1);
    csr_rd(4'd8, rd); check("post_reset_csr_beats", rd, 5);
    $display("cmd addr=00000300 len=5 mode=1 beats=%0d after reset", acc_cycle.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
